// File: rtl/mem_1r1w_ctrl_pkg.sv
// Shared types and defaults for the mem_1r1w front-end controller.
package mem_1r1w_ctrl_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } ctrl_state_t;

  localparam int DEPTH = 48;
  localparam int WIDTH = 64;
  localparam logic [WIDTH-1:0] INIT_VALUE = '0;

  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/mem_1r1w_ctrl_arb.sv
// Two-requester round-robin arbiter; priority moves to the non-granted client after each grant.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_prio;  // 0: client 0 preferred on a tie

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      if (i_req == 2'b11) o_gnt = r_prio ? 2'b10 : 2'b01;
      else                o_gnt = i_req;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    r_prio <= 1'b0;
    else if (|o_gnt) r_prio <= o_gnt[0];
  end

endmodule

// File: rtl/mem_1r1w_ctrl.sv
// Front-end for the 1R1W memory macro: init sweep, write-port round-robin, 1-cycle reads with
// write-first bypass and out-of-range protection.
//   state    | meaning
//   ST_INIT  | sweeping INIT_VALUE into every entry, clients held off
//   ST_READY | serving the read client and both write clients
module mem_1r1w_ctrl
  import mem_1r1w_ctrl_pkg::*;
#(
  parameter int DEPTH = mem_1r1w_ctrl_pkg::DEPTH,
  parameter int WIDTH = mem_1r1w_ctrl_pkg::WIDTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] INIT_VALUE = WIDTH'(mem_1r1w_ctrl_pkg::INIT_VALUE)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear_req,
  output logic              init_done,
  input  logic              wr0_valid,
  output logic              wr0_ready,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [WIDTH-1:0]  wr0_data,
  input  logic              wr1_valid,
  output logic              wr1_ready,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [WIDTH-1:0]  wr1_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              oob_err,
  output logic [ADDR_W-1:0] mem_R0_addr,
  output logic              mem_R0_en,
  input  logic [WIDTH-1:0]  mem_R0_data,
  output logic [ADDR_W-1:0] mem_W0_addr,
  output logic              mem_W0_en,
  output logic [WIDTH-1:0]  mem_W0_data
);

  ctrl_state_t       r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_rsp_valid;
  logic              r_rsp_inr;
  logic              r_byp_hit;
  logic [WIDTH-1:0]  r_byp_data;
  logic [WIDTH-1:0]  r_rsp_hold;
  logic              r_oob;

  logic              w_ready;
  logic [1:0]        w_gnt;
  logic              w_wr_acc;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [WIDTH-1:0]  w_wr_data;
  logic              w_wr_inr;
  logic              w_rd_acc;
  logic              w_rd_inr;
  logic              w_byp;
  logic [WIDTH-1:0]  w_rsp_mux;

  assign w_ready = (r_state == ST_READY);

  rr_arb2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .i_en    (w_ready),
    .i_req   ({wr1_valid, wr0_valid}),
    .o_gnt   (w_gnt)
  );

  assign wr0_ready = w_gnt[0];
  assign wr1_ready = w_gnt[1];
  assign rd_ready  = w_ready;
  assign init_done = w_ready;

  assign w_wr_acc  = |w_gnt;
  assign w_wr_addr = w_gnt[1] ? wr1_addr : wr0_addr;
  assign w_wr_data = w_gnt[1] ? wr1_data : wr0_data;
  assign w_wr_inr  = addr_in_range(32'(w_wr_addr), 32'(DEPTH));
  assign w_rd_acc  = rd_valid & w_ready;
  assign w_rd_inr  = addr_in_range(32'(rd_addr), 32'(DEPTH));
  assign w_byp     = w_rd_acc & w_rd_inr & w_wr_acc & w_wr_inr & (rd_addr == w_wr_addr);

  assign mem_R0_en   = w_rd_acc & w_rd_inr;
  assign mem_R0_addr = rd_addr;

  // The sweep write must already be on the port for the first edge after reset release,
  // but stays off while reset is held.
  always_comb begin
    mem_W0_en   = 1'b0;
    mem_W0_addr = w_wr_addr;
    mem_W0_data = w_wr_data;
    if (r_state == ST_INIT) begin
      mem_W0_en   = reset_n;
      mem_W0_addr = r_cnt;
      mem_W0_data = INIT_VALUE;
    end else begin
      mem_W0_en   = w_wr_acc & w_wr_inr;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_cnt == ADDR_W'(DEPTH - 1)) begin
            r_state <= ST_READY;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        ST_READY: begin
          if (clear_req) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign w_rsp_mux = !r_rsp_inr ? '0 : (r_byp_hit ? r_byp_data : mem_R0_data);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_valid ? w_rsp_mux : r_rsp_hold;
  assign oob_err   = r_oob;

  // Macro data only exists in the response cycle, so it is captured to hold rsp_data afterwards.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_inr   <= 1'b0;
      r_byp_hit   <= 1'b0;
      r_byp_data  <= '0;
      r_rsp_hold  <= '0;
      r_oob       <= 1'b0;
    end else begin
      r_rsp_valid <= w_rd_acc;
      r_rsp_inr   <= w_rd_inr;
      r_byp_hit   <= w_byp;
      if (w_byp)       r_byp_data <= w_wr_data;
      if (r_rsp_valid) r_rsp_hold <= w_rsp_mux;
      if ((w_wr_acc & ~w_wr_inr) | (w_rd_acc & ~w_rd_inr)) r_oob <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_1r1w_ctrl.sv
// Directed and randomized bench for mem_1r1w_ctrl against a behavioural memory/arbiter model.
module tb_mem_1r1w_ctrl;
  localparam int DEPTH = 48;
  localparam int WIDTH = 64;
  localparam int ADDR_W = 6;

  logic clock = 1'b0;
  logic reset_n, clear_req, init_done;
  logic wr0_valid, wr0_ready, wr1_valid, wr1_ready, rd_valid, rd_ready;
  logic [ADDR_W-1:0] wr0_addr, wr1_addr, rd_addr, mem_R0_addr, mem_W0_addr;
  logic [WIDTH-1:0]  wr0_data, wr1_data, rsp_data, mem_R0_data, mem_W0_data;
  logic rsp_valid, oob_err, mem_R0_en, mem_W0_en;

  always #5 clock = ~clock;

  mem_1r1w_ctrl dut (
    .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .init_done(init_done),
    .wr0_valid(wr0_valid), .wr0_ready(wr0_ready), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_valid(wr1_valid), .wr1_ready(wr1_ready), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .oob_err(oob_err),
    .mem_R0_addr(mem_R0_addr), .mem_R0_en(mem_R0_en), .mem_R0_data(mem_R0_data),
    .mem_W0_addr(mem_W0_addr), .mem_W0_en(mem_W0_en), .mem_W0_data(mem_W0_data)
  );

  // Macro: synchronous read (old data on collision), synchronous write; seeded with garbage.
  logic [WIDTH-1:0] macro [64];
  logic seed;
  always @(posedge clock) begin
    if (seed) begin
      for (int i = 0; i < 64; i++) macro[i] <= {$urandom, $urandom};
    end else begin
      if (mem_W0_en) macro[mem_W0_addr] <= mem_W0_data;
      if (mem_R0_en) mem_R0_data <= macro[mem_R0_addr];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] ref_mem [DEPTH];
  bit m_ready, m_prio, m_oob;
  int m_cnt;
  logic [WIDTH-1:0] m_rsp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, got, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ready = 1'b0;
    m_cnt   = 0;
    m_prio  = 1'b0;
    m_oob   = 1'b0;
    m_rsp   = '0;
  endtask

  task automatic check_reset_outputs();
    chk1("rst_init_done", init_done, 1'b0);
    chk1("rst_wr0_ready", wr0_ready, 1'b0);
    chk1("rst_wr1_ready", wr1_ready, 1'b0);
    chk1("rst_rd_ready", rd_ready, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 64'h0);
    chk1("rst_oob_err", oob_err, 1'b0);
    chk1("rst_R0_en", mem_R0_en, 1'b0);
    chk1("rst_W0_en", mem_W0_en, 1'b0);
  endtask

  task automatic set_idle();
    wr0_valid = 1'b0;
    wr1_valid = 1'b0;
    rd_valid  = 1'b0;
    clear_req = 1'b0;
  endtask

  // Called right after a negedge with inputs already driven; ends on the next negedge.
  task automatic step();
    logic [1:0] g;
    logic wr_acc, wr_inr, rd_acc, rd_inr;
    logic [ADDR_W-1:0] wa;
    logic [WIDTH-1:0] wd;
    #1;
    g = 2'b00;
    if (m_ready) begin
      if (wr0_valid && wr1_valid) g = m_prio ? 2'b10 : 2'b01;
      else                        g = {wr1_valid, wr0_valid};
    end
    chk1("wr0_ready", wr0_ready, g[0]);
    chk1("wr1_ready", wr1_ready, g[1]);
    chk1("rd_ready", rd_ready, m_ready);
    chk1("init_done", init_done, m_ready);
    wr_acc = (g != 2'b00);
    wa = g[1] ? wr1_addr : wr0_addr;
    wd = g[1] ? wr1_data : wr0_data;
    wr_inr = (wa < DEPTH);
    rd_acc = m_ready && rd_valid;
    rd_inr = (rd_addr < DEPTH);
    if (!m_ready) begin
      chk1("sweep_W0_en", mem_W0_en, 1'b1);
      chka("sweep_W0_addr", mem_W0_addr, 6'(m_cnt));
      chk("sweep_W0_data", mem_W0_data, 64'h0);
    end else begin
      chk1("W0_en", mem_W0_en, wr_acc && wr_inr);
      if (wr_acc && wr_inr) begin
        chka("W0_addr", mem_W0_addr, wa);
        chk("W0_data", mem_W0_data, wd);
      end
      chk1("R0_en", mem_R0_en, rd_acc && rd_inr);
      if (rd_acc && rd_inr) chka("R0_addr", mem_R0_addr, rd_addr);
    end
    // write-first: apply this cycle's write before resolving this cycle's read
    if (!m_ready) ref_mem[m_cnt] = '0;
    else if (wr_acc && wr_inr) ref_mem[wa] = wd;
    if (rd_acc) m_rsp = rd_inr ? ref_mem[rd_addr] : '0;
    if ((wr_acc && !wr_inr) || (rd_acc && !rd_inr)) m_oob = 1'b1;
    if (wr_acc) m_prio = g[0];
    if (!m_ready) begin
      if (m_cnt == DEPTH - 1) begin
        m_ready = 1'b1;
        m_cnt   = 0;
      end else begin
        m_cnt++;
      end
    end else if (clear_req) begin
      m_ready = 1'b0;
      m_cnt   = 0;
    end
    @(posedge clock);
    @(negedge clock);
    chk1("rsp_valid", rsp_valid, rd_acc);
    chk("rsp_data", rsp_data, m_rsp);
    chk1("oob_err", oob_err, m_oob);
  endtask

  initial begin
    set_idle();
    wr0_addr = '0; wr1_addr = '0; rd_addr = 6'd5;
    wr0_data = '0; wr1_data = '0;
    seed = 1'b1;
    reset_n = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    model_reset();
    rd_valid = 1'b1;
    wr0_valid = 1'b1;
    #1;
    check_reset_outputs();

    // Sweep after reset with a read pending; then read addr 5 in cycle 48.
    @(negedge clock);
    seed = 1'b0;
    wr0_valid = 1'b0;
    reset_n = 1'b1;
    repeat (DEPTH + 1) step();

    // Both writers valid: grants alternate, then read back.
    set_idle();
    wr0_valid = 1'b1; wr0_addr = 6'd1;
    wr1_valid = 1'b1; wr1_addr = 6'd2;
    repeat (6) begin
      wr0_data = {$urandom, $urandom};
      wr1_data = {$urandom, $urandom};
      step();
    end
    set_idle();
    rd_valid = 1'b1; rd_addr = 6'd1; step();
    rd_addr = 6'd2; step();

    // Same-cycle write/read collision.
    set_idle();
    wr0_valid = 1'b1; wr0_addr = 6'd10; wr0_data = 64'hDEAD_BEEF_0000_0001;
    rd_valid = 1'b1; rd_addr = 6'd10;
    step();
    chk("bypass_rsp", rsp_data, 64'hDEAD_BEEF_0000_0001);

    // Out-of-range write and read.
    set_idle();
    wr1_valid = 1'b1; wr1_addr = 6'd50; wr1_data = 64'h1234;
    rd_valid = 1'b1; rd_addr = 6'd63;
    step();
    chk1("oob_set", oob_err, 1'b1);
    set_idle();
    repeat (3) step();

    // Clear request concurrent with a read.
    wr0_valid = 1'b1; wr0_addr = 6'd3; wr0_data = 64'h55;
    step();
    set_idle();
    rd_valid = 1'b1; rd_addr = 6'd3; clear_req = 1'b1;
    step();
    chk("clear_rsp", rsp_data, 64'h55);
    set_idle();
    repeat (DEPTH) step();
    rd_valid = 1'b1; rd_addr = 6'd3;
    step();
    chk("after_clear_rsp", rsp_data, 64'h0);

    // Randomized traffic, including rare clears.
    repeat (400) begin
      wr0_valid = 1'($urandom_range(0, 1));
      wr1_valid = 1'($urandom_range(0, 1));
      rd_valid  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) begin
        wr0_addr = 6'($urandom_range(0, 7));
        wr1_addr = 6'($urandom_range(0, 7));
        rd_addr  = 6'($urandom_range(0, 7));
      end else begin
        wr0_addr = 6'($urandom_range(0, 63));
        wr1_addr = 6'($urandom_range(0, 63));
        rd_addr  = 6'($urandom_range(0, 63));
      end
      wr0_data = {$urandom, $urandom};
      wr1_data = {$urandom, $urandom};
      clear_req = ($urandom_range(0, 99) == 0);
      step();
    end

    // Reset asserted in cycle 20 of a sweep.
    set_idle();
    for (int i = 0; i < 60 && !m_ready; i++) step();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    rd_valid = 1'b1; rd_addr = 6'd10;
    repeat (20) step();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (DEPTH + 1) step();
    chk("post_reset_read", rsp_data, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_1r1w_ctrl.md
# mem_1r1w_ctrl

Front-end controller for the `mem_1r1w` lowered macro (48 x 64, one read port, one write port). It runs a zero-initialisation sweep after reset or on request. It arbitrates the single write port between two write clients using round-robin. It serves one read client with fixed 1-cycle latency, including write-first bypass on same-cycle address collision and out-of-range address protection.

## Interface
Parameters:
- `DEPTH`, 48, logical entries; legal addresses are 0..DEPTH-1.
- `WIDTH`, 64, data width in bits.
- `ADDR_W`, $clog2(DEPTH) = 6, address width.
- `INIT_VALUE`, 0, WIDTH-bit value written by the init sweep.

Ports:
- `clock`  in  1  sole clock; also drives the macro `R0_clk` and `W0_clk` externally.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clear_req`  in  1  single-cycle pulse; restarts the init sweep.
- `init_done`  out  1  high while in READY.
- `wr0_valid` / `wr0_ready`  in / out  1  write client 0 handshake.
- `wr0_addr` / `wr0_data`  in  ADDR_W / WIDTH  write client 0 address and data.
- `wr1_valid` / `wr1_ready` / `wr1_addr` / `wr1_data`  same as client 0, for write client 1.
- `rd_valid` / `rd_ready`  in / out  1  read request handshake.
- `rd_addr`  in  ADDR_W  read address.
- `rsp_valid`  out  1  read response strobe; no backpressure.
- `rsp_data`  out  WIDTH  read response data.
- `oob_err`  out  1  sticky flag for an out-of-range access; cleared only by reset.
- `mem_R0_addr` / `mem_R0_en`  out  ADDR_W / 1  to the macro read port.
- `mem_R0_data`  in  WIDTH  from the macro read port.
- `mem_W0_addr` / `mem_W0_en` / `mem_W0_data`  out  ADDR_W / 1 / WIDTH  to the macro write port.

## Operation
- States:
  - ST_INIT, which sweeps the memory.
  - ST_READY, which serves clients.
- State transitions:
  - Reset sends the controller to ST_INIT with the sweep counter at 0.
  - ST_INIT moves to ST_READY after the write to DEPTH-1.
  - ST_READY moves to ST_INIT when `clear_req` is high; the counter restarts at 0.
  - `clear_req` is ignored while in ST_INIT.
- In ST_INIT:
  - `mem_W0_en`=1, `mem_W0_addr`=counter, `mem_W0_data`=INIT_VALUE; the counter increments each cycle.
  - All `*_ready`=0.
- In ST_READY:
  - `rd_ready`=1.
  - `wrN_ready` is the combinational grant from a 2-way round-robin arbiter.
  - The arbiter grants only a requester that is valid; at most one write is accepted per cycle.
  - After reset, client 0 has priority.
  - Priority pointer: after any grant, priority goes to the non-granted client.
  - A lone valid client is granted every cycle.
- Accepted write with addr < DEPTH: drive `mem_W0_*` in the same cycle.
- Accepted write with addr >= DEPTH: the handshake completes, `mem_W0_en` stays 0, and `oob_err` is set.
- Accepted read with addr < DEPTH: drive `mem_R0_en`=1 and `mem_R0_addr` in the same cycle.
- Accepted read with addr >= DEPTH: `mem_R0_en`=0, the response data is 0, and `oob_err` is set.
- Bypass: if a read and a write are accepted in the same cycle to the same in-range address, the response carries the write data (write-first). The macro read output is ignored for that response.
- Per read, register the in-range flag, the bypass-hit flag and the bypass data to select the response mux source one cycle later.
- `clear_req` in the same cycle as an accepted read or write:
  - The access still completes.
  - The response returns normally.
  - The sweep then overwrites that entry.

## Timing
- Reset values: `init_done`=0, all `*_ready`=0, `rsp_valid`=0, `rsp_data`=0, `oob_err`=0, `mem_R0_en`=0, `mem_W0_en`=0.
- Init sweep:
  - The first sweep write occurs on the first clock edge after reset deassertion.
  - The sweep takes exactly DEPTH cycles.
  - `init_done` rises in cycle DEPTH, counted from 0.
- Read latency: a read accepted in cycle T gives `rsp_valid`=1 and valid `rsp_data` in T+1.
- `rsp_valid` and `rsp_data` are registered; `rsp_data` holds its value when `rsp_valid`=0.
- A write accepted in T is visible to a read accepted in T (via bypass) or in any later cycle (via the macro).
- Read and write throughput: 1 per cycle each, concurrently.
- Asserting `reset_n` low mid-sweep or mid-access:
  - All outputs drop to their reset values immediately.
  - A pending response is lost.

## Structure
- Package `mem_1r1w_ctrl_pkg` holds:
  - the state enum `ctrl_state_t` {ST_INIT, ST_READY};
  - the default constants DEPTH, WIDTH, INIT_VALUE;
  - the `addr_in_range` function.
- Sub-module `rr_arb2`: a 2-requester round-robin arbiter.
  - Inputs: req[1:0] and an enable.
  - Outputs: a one-hot grant.
  - It holds the priority pointer register and resets to client 0 priority.
- Everything else is in the top level: FSM and counter, read pipeline register, bypass compare, `oob_err`.

## Test plan
- Release reset with reads requested → no ready for 48 cycles; `mem_W0_en` is high at addresses 0..47 with data 0; `init_done`=1 at cycle 48; a subsequent read of addr 5 returns 0.
- Both write clients valid continuously, wr0 to addr 1 and wr1 to addr 2 → grants alternate 0,1,0,1; then reading addr 1 and addr 2 returns the last data written by each client.
- Write 0xDEAD_BEEF_0000_0001 to addr 10 and read addr 10 in the same cycle → `rsp_data`=0xDEAD_BEEF_0000_0001 in the next cycle, independent of the macro output.
- Write to addr 50 and read addr 63 → both handshakes complete; no macro enable; `rsp_data`=0; `oob_err` stays 1 until reset.
- Write addr 3 with 0x55, then pulse `clear_req` in the same cycle as a read of addr 3 → the response is 0x55; `init_done` drops for 48 cycles; a later read of addr 3 returns 0.
- Drive `reset_n` low during cycle 20 of the sweep → outputs are at reset values immediately; after release, a full 48-cycle sweep restarts from address 0.
